mem_ctrl: RTL and testbench

Byte-serial memory controller between the 8-bit unified RAM port and the two 32-bit clients: the instruction fetcher and the load/store buffer (LSB). It serves the fetcher's word-read requests and the LSB's 1/2/4-byte loads and stores by sequencing one RAM byte per cycle. It assembles or splits words little-endian and returns a one-cycle ready pulse to the owning client. It arbitrates between the two clients and aborts in-flight instruction fetches on pipeline flush.

---
 rtl/mem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller serving instruction fetch and load/store clients
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  if_ena,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [31:0]           if_data,
  input  logic                  ls_ena,
  input  logic                  ls_wr,
  input  logic [1:0]            ls_size,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_ready,
  output logic [31:0]           ls_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic                  own_ls_q, own_ls_d;     // 1 = LSB owns the transfer, 0 = fetcher
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            n_q, n_d;               // byte count 1/2/4
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            cyc_q, cyc_d;           // index of the byte currently on mem_a
  logic [31:0]           data_q, data_d;         // read assembly buffer
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  if_ready_q, if_ready_d;
  logic                  ls_ready_q, ls_ready_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           ls_rdata_q, ls_rdata_d;

  logic [2:0]            cyc_nxt;
  logic [ADDR_WIDTH-1:0] a_nxt;
  logic [1:0]            cap_idx;
  logic [31:0]           cap_word;

  // Arbitration, byte sequencing and little-endian assembly/split
  always_comb begin
    state_d    = state_q;
    own_ls_d   = own_ls_q;
    addr_d     = addr_q;
    n_d        = n_q;
    wdata_d    = wdata_q;
    cyc_d      = cyc_q;
    data_d     = data_q;
    mem_a_d    = mem_a_q;
    mem_wr_d   = 1'b0;
    mem_dout_d = mem_dout_q;
    if_ready_d = 1'b0;
    ls_ready_d = 1'b0;
    if_data_d  = 32'd0;
    ls_rdata_d = 32'd0;

    cyc_nxt  = cyc_q + 3'd1;
    a_nxt    = addr_q + {{(ADDR_WIDTH-3){1'b0}}, cyc_nxt};
    // mem_din in this cycle belongs to the byte addressed one cycle earlier
    cap_idx  = cyc_q[1:0] - 2'd1;
    cap_word = data_q | ({24'd0, mem_din} << {cap_idx, 3'b000});

    case (state_q)
      IDLE: begin
        if (ls_ena) begin
          own_ls_d = 1'b1;
          addr_d   = ls_addr;
          wdata_d  = ls_wdata;
          cyc_d    = 3'd0;
          data_d   = 32'd0;
          mem_a_d  = ls_addr;
          case (ls_size)
            2'd0:    n_d = 3'd1;
            2'd1:    n_d = 3'd2;
            default: n_d = 3'd4;
          endcase
          if (ls_wr) begin
            state_d    = WRITE;
            mem_wr_d   = 1'b1;
            mem_dout_d = ls_wdata[7:0];
          end else begin
            state_d = READ;
          end
        end else if (if_ena && !flush) begin
          own_ls_d = 1'b0;
          addr_d   = if_addr;
          n_d      = 3'd4;
          cyc_d    = 3'd0;
          data_d   = 32'd0;
          mem_a_d  = if_addr;
          state_d  = READ;
        end
      end
      READ: begin
        if (!own_ls_q && flush) begin
          state_d = IDLE;
        end else begin
          if (cyc_q != 3'd0) data_d = cap_word;
          if (cyc_q == n_q) begin
            state_d = DONE;
            if (own_ls_q) begin
              ls_ready_d = 1'b1;
              ls_rdata_d = cap_word;
            end else begin
              if_ready_d = 1'b1;
              if_data_d  = cap_word;
            end
          end else begin
            cyc_d = cyc_nxt;
            if (cyc_nxt < n_q) mem_a_d = a_nxt;
          end
        end
      end
      WRITE: begin
        if (cyc_q == n_q - 3'd1) begin
          state_d    = DONE;
          ls_ready_d = 1'b1;
        end else begin
          cyc_d      = cyc_nxt;
          mem_wr_d   = 1'b1;
          mem_a_d    = a_nxt;
          mem_dout_d = 8'(wdata_q >> {cyc_nxt[1:0], 3'b000});
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      own_ls_q   <= 1'b0;
      addr_q     <= '0;
      n_q        <= 3'd0;
      wdata_q    <= 32'd0;
      cyc_q      <= 3'd0;
      data_q     <= 32'd0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
      mem_dout_q <= 8'd0;
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      if_data_q  <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      own_ls_q   <= own_ls_d;
      addr_q     <= addr_d;
      n_q        <= n_d;
      wdata_q    <= wdata_d;
      cyc_q      <= cyc_d;
      data_q     <= data_d;
      mem_a_q    <= mem_a_d;
      mem_wr_q   <= mem_wr_d;
      mem_dout_q <= mem_dout_d;
      if_ready_q <= if_ready_d;
      ls_ready_q <= ls_ready_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  // A flush arriving in the ready cycle still cancels the stale fetch word
  assign if_ready = if_ready_q & ~flush;
  assign if_data  = if_data_q;
  assign ls_ready = ls_ready_q;
  assign ls_rdata = ls_rdata_q;
  assign mem_a    = mem_a_q;
  assign mem_wr   = mem_wr_q;
  assign mem_dout = mem_dout_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_ena;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_data;
  logic        ls_ena;
  logic        ls_wr;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ready;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [0:1023];
  int          n_checks = 0;
  int          n_fail   = 0;

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_ena(if_ena), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
    .ls_ena(ls_ena), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // RAM model: read data appears the cycle after its address
  always @(posedge clk) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h10; ram[10'h103] = 8'h00;
    ram[10'h020] = 8'hFF;
    ram[10'h042] = 8'h77;
    rst_n = 1'b0; flush = 1'b0; if_ena = 1'b0; if_addr = 32'd0;
    ls_ena = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;

    // reset state
    tick(); tick();
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_ls_ready", {31'd0, ls_ready}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // word fetch at 0x100
    if_ena = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fetch_addr", mem_a, 32'h100 + i);
      chk("fetch_no_ready", {31'd0, if_ready}, 32'd0);
    end
    tick();
    chk("fetch_c5_ready", {31'd0, if_ready}, 32'd0);
    tick();
    chk("fetch_ready", {31'd0, if_ready}, 32'd1);
    chk("fetch_data", if_data, 32'h00100513);
    if_ena = 1'b0;
    tick();
    chk("fetch_pulse_end", {31'd0, if_ready}, 32'd0);
    chk("fetch_a_hold", mem_a, 32'h103);

    // simultaneous requests: byte load wins
    if_ena = 1'b1; if_addr = 32'h100;
    ls_ena = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h20;
    tick();
    chk("arb_ls_addr", mem_a, 32'h20);
    tick();
    chk("arb_ls_c2", {31'd0, ls_ready}, 32'd0);
    tick();
    chk("arb_ls_ready", {31'd0, ls_ready}, 32'd1);
    chk("arb_ls_rdata", ls_rdata, 32'h000000FF);
    chk("arb_if_quiet", {31'd0, if_ready}, 32'd0);
    ls_ena = 1'b0;
    tick();
    chk("arb_done_no_accept", mem_a, 32'h20);
    chk("arb_ls_pulse_end", {31'd0, ls_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arb_fetch_addr", mem_a, 32'h100 + i);
    end
    tick();
    tick();
    chk("arb_fetch_ready", {31'd0, if_ready}, 32'd1);
    chk("arb_fetch_data", if_data, 32'h00100513);
    if_ena = 1'b0;
    tick();

    // half store 0xABCD at 0x40
    ls_ena = 1'b1; ls_wr = 1'b1; ls_size = 2'd1; ls_addr = 32'h40; ls_wdata = 32'h1234ABCD;
    tick();
    chk("hst_wr1", {31'd0, mem_wr}, 32'd1);
    chk("hst_a1", mem_a, 32'h40);
    chk("hst_d1", {24'd0, mem_dout}, 32'hCD);
    tick();
    chk("hst_wr2", {31'd0, mem_wr}, 32'd1);
    chk("hst_a2", mem_a, 32'h41);
    chk("hst_d2", {24'd0, mem_dout}, 32'hAB);
    chk("hst_not_ready", {31'd0, ls_ready}, 32'd0);
    tick();
    chk("hst_wr_off", {31'd0, mem_wr}, 32'd0);
    chk("hst_ready", {31'd0, ls_ready}, 32'd1);
    ls_ena = 1'b0; ls_wr = 1'b0;
    tick();
    chk("hst_ram40", {24'd0, ram[10'h040]}, 32'hCD);
    chk("hst_ram41", {24'd0, ram[10'h041]}, 32'hAB);
    chk("hst_ram42", {24'd0, ram[10'h042]}, 32'h77);

    // flush after two fetch bytes captured, held load follows
    if_ena = 1'b1; if_addr = 32'h100;
    tick(); tick(); tick(); tick();
    flush = 1'b1; if_ena = 1'b0;
    ls_ena = 1'b1; ls_wr = 1'b0; ls_size = 2'd0; ls_addr = 32'h20;
    tick();
    chk("fl_no_ready_c5", {31'd0, if_ready}, 32'd0);
    chk("fl_ls_not_yet", mem_a, 32'h103);
    flush = 1'b0;
    tick();
    chk("fl_ls_addr", mem_a, 32'h20);
    chk("fl_no_ready_c6", {31'd0, if_ready}, 32'd0);
    tick();
    chk("fl_ls_c7", {31'd0, ls_ready}, 32'd0);
    tick();
    chk("fl_ls_ready", {31'd0, ls_ready}, 32'd1);
    chk("fl_ls_rdata", ls_rdata, 32'h000000FF);
    chk("fl_if_quiet", {31'd0, if_ready}, 32'd0);
    ls_ena = 1'b0;
    tick();

    // word store at 0x44 with flush in the middle
    ls_ena = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h44; ls_wdata = 32'hDEADBEEF;
    tick();
    chk("wst_d1", {24'd0, mem_dout}, 32'hEF);
    flush = 1'b1;
    tick();
    chk("wst_a2", mem_a, 32'h45);
    chk("wst_d2", {24'd0, mem_dout}, 32'hBE);
    tick();
    chk("wst_d3", {24'd0, mem_dout}, 32'hAD);
    flush = 1'b0;
    tick();
    chk("wst_wr4", {31'd0, mem_wr}, 32'd1);
    chk("wst_a4", mem_a, 32'h47);
    chk("wst_d4", {24'd0, mem_dout}, 32'hDE);
    tick();
    chk("wst_wr_off", {31'd0, mem_wr}, 32'd0);
    chk("wst_ready", {31'd0, ls_ready}, 32'd1);
    ls_ena = 1'b0; ls_wr = 1'b0;
    tick();
    chk("wst_ram", {ram[10'h047], ram[10'h046], ram[10'h045], ram[10'h044]}, 32'hDEADBEEF);

    // size 3 load treated as word
    ls_ena = 1'b1; ls_size = 2'd3; ls_addr = 32'h44;
    tick(); tick(); tick(); tick(); tick();
    chk("ld3_c5", {31'd0, ls_ready}, 32'd0);
    tick();
    chk("ld3_ready", {31'd0, ls_ready}, 32'd1);
    chk("ld3_rdata", ls_rdata, 32'hDEADBEEF);
    ls_ena = 1'b0;
    tick();

    // flush on the edge that would capture the last fetch byte
    if_ena = 1'b1; if_addr = 32'h100;
    tick(); tick(); tick(); tick(); tick();
    flush = 1'b1; if_ena = 1'b0;
    tick();
    chk("flast_no_ready", {31'd0, if_ready}, 32'd0);
    flush = 1'b0;
    tick();
    chk("flast_still_quiet", {31'd0, if_ready}, 32'd0);

    // reset in the middle of a store drops mem_wr asynchronously
    ls_ena = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h80; ls_wdata = 32'h11223344;
    tick(); tick();
    chk("rstw_wr_before", {31'd0, mem_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_wr_async", {31'd0, mem_wr}, 32'd0);
    chk("rstw_a_async", mem_a, 32'd0);
    ls_ena = 1'b0; ls_wr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // reset in the middle of a fetch, then a fresh fetch
    if_ena = 1'b1; if_addr = 32'h100;
    tick(); tick(); tick();
    chk("rstr_a_before", mem_a, 32'h102);
    rst_n = 1'b0;
    #1;
    chk("rstr_a_async", mem_a, 32'd0);
    chk("rstr_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rstr_mem_wr", {31'd0, mem_wr}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstr_fetch_addr", mem_a, 32'h100 + i);
    end
    tick();
    chk("rstr_c5", {31'd0, if_ready}, 32'd0);
    tick();
    chk("rstr_ready", {31'd0, if_ready}, 32'd1);
    chk("rstr_data", if_data, 32'h00100513);
    if_ena = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
